// File: rtl/dpi_feeder_pkg.sv
// dpi_feeder_pkg: shared constants, FSM state type and the saturating-increment helper used by
// dpi_stream_feeder and dpi_stream_table.
package dpi_feeder_pkg;

  localparam int unsigned NUM_STREAMS = 64;
  localparam int unsigned SID_W       = 6;
  localparam int unsigned KEY_W       = 32;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StLoad,
    StWait,
    StStream,
    StGap
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dpi_stream_table.sv
// dpi_stream_table: 64-entry flow-key -> stream-id table with per-stream category masks.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset (clears valid bits and victim)
//   i_key                  key under lookup / key written on allocation
//   o_hit, o_hit_sid       parallel-compare result over valid entries
//   o_full, o_alloc_sid    table full flag; lowest free entry, or the victim when full
//   i_alloc, i_alloc_sid   write key, set valid, load i_default_mask into the entry
//   i_evict                advance the round-robin victim pointer
//   i_cfg_we/sid/mask      mask write port, usable in any cycle
//   i_rd_sid, o_rd_mask    mask read port
module dpi_stream_table
  import dpi_feeder_pkg::*;
#(
  parameter int unsigned NUM_CAT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [KEY_W-1:0]   i_key,
  output logic               o_hit,
  output logic [SID_W-1:0]   o_hit_sid,
  output logic               o_full,
  output logic [SID_W-1:0]   o_alloc_sid,
  input  logic               i_alloc,
  input  logic [SID_W-1:0]   i_alloc_sid,
  input  logic               i_evict,
  input  logic               i_cfg_we,
  input  logic [SID_W-1:0]   i_cfg_sid,
  input  logic [NUM_CAT-1:0] i_cfg_mask,
  input  logic [NUM_CAT-1:0] i_default_mask,
  input  logic [SID_W-1:0]   i_rd_sid,
  output logic [NUM_CAT-1:0] o_rd_mask
);

  logic [NUM_STREAMS-1:0] r_valid;
  logic [KEY_W-1:0]       r_key  [NUM_STREAMS];
  logic [NUM_CAT-1:0]     r_mask [NUM_STREAMS];
  logic [SID_W-1:0]       r_victim;
  logic [SID_W-1:0]       w_free_sid;

  // Scanning downwards lets the lowest matching index win both encoders.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_sid  = '0;
    o_full     = 1'b1;
    w_free_sid = '0;
    for (int i = int'(NUM_STREAMS) - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_key[i] == i_key)) begin
        o_hit     = 1'b1;
        o_hit_sid = SID_W'(i);
      end
      if (!r_valid[i]) begin
        o_full     = 1'b0;
        w_free_sid = SID_W'(i);
      end
    end
  end

  assign o_alloc_sid = o_full ? r_victim : w_free_sid;
  assign o_rd_mask   = r_mask[i_rd_sid];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= '0;
      r_victim <= '0;
    end else begin
      if (i_alloc) r_valid[i_alloc_sid] <= 1'b1;
      if (i_evict) r_victim <= r_victim + 1'b1;  // wraps modulo 64
    end
  end

  // Allocation is written last so its default mask beats a same-entry cfg write.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we) r_mask[i_cfg_sid] <= i_cfg_mask;
    if (i_alloc) begin
      r_mask[i_alloc_sid] <= i_default_mask;
      r_key[i_alloc_sid]  <= i_key;
    end
  end

endmodule

// File: rtl/dpi_stream_feeder.sv
// dpi_stream_feeder: maps byte-serial keyed packets onto matcher streams and sequences
// load_state / characters / eop towards the regex matcher bank.
// Optional feature: define DPI_FEEDER_EVICT_EN to evict a round-robin victim when the stream
// table is full; otherwise a full-table miss drops the packet.
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_pkt_*, o_pkt_rdy          byte input with sop/eop/key, ready handshake
//   i_cfg_we/sid/mask           per-stream mask write; i_cfg_default_mask loaded on allocation
//   o_load_state, o_new_stream_id, o_stream_id, o_enable   matcher stream setup
//   o_char_in, o_char_in_vld, o_eop                          matcher character stream
//   o_pkt_cnt, o_drop_cnt       saturating packet counters
module dpi_stream_feeder
  import dpi_feeder_pkg::*;
#(
  parameter int unsigned NUM_CAT = 16,
  parameter int unsigned EOP_GAP = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pkt_vld,
  input  logic               i_pkt_sop,
  input  logic               i_pkt_eop,
  input  logic [7:0]         i_pkt_data,
  input  logic [KEY_W-1:0]   i_pkt_key,
  output logic               o_pkt_rdy,
  input  logic               i_cfg_we,
  input  logic [SID_W-1:0]   i_cfg_sid,
  input  logic [NUM_CAT-1:0] i_cfg_mask,
  input  logic [NUM_CAT-1:0] i_cfg_default_mask,
  output logic               o_load_state,
  output logic               o_new_stream_id,
  output logic [SID_W-1:0]   o_stream_id,
  output logic [7:0]         o_char_in,
  output logic               o_char_in_vld,
  output logic               o_eop,
  output logic [NUM_CAT-1:0] o_enable,
  output logic [CNT_W-1:0]   o_pkt_cnt,
  output logic [CNT_W-1:0]   o_drop_cnt
);

  localparam logic [2:0] GapLast = 3'(EOP_GAP);

  state_e             r_state, w_state_nxt;
  logic [KEY_W-1:0]   r_key;
  logic [7:0]         r_sop_byte;
  logic               r_sop_eop;
  logic [SID_W-1:0]   r_sid;
  logic               r_new;
  logic [NUM_CAT-1:0] r_enable;
  logic [7:0]         r_char;
  logic               r_char_vld;
  logic [2:0]         r_gap;
  logic [CNT_W-1:0]   r_pkt_cnt, r_drop_cnt;

  logic               w_hit, w_full;
  logic [SID_W-1:0]   w_hit_sid, w_alloc_sid;
  logic [NUM_CAT-1:0] w_hit_mask;
  logic               w_accept, w_alloc, w_evict, w_drop, w_gap_done;

  dpi_stream_table #(
    .NUM_CAT(NUM_CAT)
  ) u_table (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_key          (r_key),
    .o_hit          (w_hit),
    .o_hit_sid      (w_hit_sid),
    .o_full         (w_full),
    .o_alloc_sid    (w_alloc_sid),
    .i_alloc        (w_alloc),
    .i_alloc_sid    (w_alloc_sid),
    .i_evict        (w_evict),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_sid      (i_cfg_sid),
    .i_cfg_mask     (i_cfg_mask),
    .i_default_mask (i_cfg_default_mask),
    .i_rd_sid       (w_hit_sid),
    .o_rd_mask      (w_hit_mask)
  );

  always_comb begin
    w_state_nxt = r_state;
    o_pkt_rdy   = 1'b0;
    w_alloc     = 1'b0;
    w_evict     = 1'b0;
    w_drop      = 1'b0;
    // GAP is entered on the cycle of the last character, so it spans EOP_GAP+1 cycles.
    w_gap_done  = (r_state == StGap) && (r_gap == GapLast);
    unique case (r_state)
      StIdle: begin
        o_pkt_rdy = 1'b1;
        if (i_pkt_vld && i_pkt_sop) w_state_nxt = StLookup;
      end
      StLookup: begin
        w_state_nxt = StLoad;
        if (!w_hit) begin
          if (!w_full) begin
            w_alloc = 1'b1;
          end else begin
`ifdef DPI_FEEDER_EVICT_EN
            w_alloc = 1'b1;
            w_evict = 1'b1;
`else
            // Remaining bytes of the dropped packet are discarded as strays in IDLE.
            w_drop      = 1'b1;
            w_state_nxt = StIdle;
`endif
          end
        end
      end
      StLoad:   w_state_nxt = StWait;
      StWait:   w_state_nxt = r_sop_eop ? StGap : StStream;
      StStream: begin
        o_pkt_rdy = 1'b1;
        if (i_pkt_vld && i_pkt_eop) w_state_nxt = StGap;
      end
      StGap: begin
        if (w_gap_done) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    w_accept = i_pkt_vld & o_pkt_rdy;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_key      <= '0;
      r_sop_byte <= '0;
      r_sop_eop  <= 1'b0;
      r_sid      <= '0;
      r_new      <= 1'b0;
      r_enable   <= '0;
      r_char     <= '0;
      r_char_vld <= 1'b0;
      r_gap      <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_char_vld <= 1'b0;
      if ((r_state == StIdle) && w_accept && i_pkt_sop) begin
        r_key      <= i_pkt_key;
        r_sop_byte <= i_pkt_data;
        r_sop_eop  <= i_pkt_eop;
      end
      if ((r_state == StLookup) && !w_drop) begin
        r_sid    <= w_hit ? w_hit_sid : w_alloc_sid;
        r_new    <= !w_hit;
        r_enable <= w_hit ? w_hit_mask : i_cfg_default_mask;
      end
      if (r_state == StWait) begin
        r_char     <= r_sop_byte;
        r_char_vld <= 1'b1;
      end
      if ((r_state == StStream) && w_accept) begin
        r_char     <= i_pkt_data;
        r_char_vld <= 1'b1;
      end
      r_gap <= (r_state == StGap) ? r_gap + 3'd1 : 3'd0;
      if (w_gap_done) r_pkt_cnt <= sat_inc(r_pkt_cnt);
      if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign o_load_state    = (r_state == StLoad);
  assign o_new_stream_id = o_load_state & r_new;
  assign o_stream_id     = r_sid;
  assign o_enable        = r_enable;
  assign o_char_in       = r_char;
  assign o_char_in_vld   = r_char_vld;
  assign o_eop           = w_gap_done;
  assign o_pkt_cnt       = r_pkt_cnt;
  assign o_drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_dpi_stream_feeder.sv
// tb_dpi_stream_feeder: scoreboard bench for dpi_stream_feeder. The stimulus side keeps a
// key->stream map model and pushes expected headers/characters; a monitor pops and compares.
module tb_dpi_stream_feeder;

  localparam int EOP_GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_vld = 0, pkt_sop = 0, pkt_eop = 0;
  logic [7:0]  pkt_data = '0;
  logic [31:0] pkt_key = '0;
  logic        pkt_rdy;
  logic        cfg_we = 0;
  logic [5:0]  cfg_sid = '0;
  logic [15:0] cfg_mask = '0, cfg_default_mask = 16'hF0F0;
  logic        load_state, new_stream_id, char_in_vld, eop;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic [15:0] enable, pkt_cnt, drop_cnt;

  always #5 clk = ~clk;

  dpi_stream_feeder #(
    .NUM_CAT(16),
    .EOP_GAP(EOP_GAP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pkt_vld(pkt_vld), .i_pkt_sop(pkt_sop), .i_pkt_eop(pkt_eop),
    .i_pkt_data(pkt_data), .i_pkt_key(pkt_key), .o_pkt_rdy(pkt_rdy), .i_cfg_we(cfg_we),
    .i_cfg_sid(cfg_sid), .i_cfg_mask(cfg_mask), .i_cfg_default_mask(cfg_default_mask),
    .o_load_state(load_state), .o_new_stream_id(new_stream_id), .o_stream_id(stream_id),
    .o_char_in(char_in), .o_char_in_vld(char_in_vld), .o_eop(eop), .o_enable(enable),
    .o_pkt_cnt(pkt_cnt), .o_drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [5:0]  sid;
    logic        nw;
    logic [15:0] en;
    logic [15:0] len;
  } hdr_t;

  hdr_t        exp_hdr[$];
  logic [7:0]  exp_chars[$];
  int          n_checks = 0, n_pass = 0;
  int          exp_pkts = 0, exp_drops = 0;

  // Reference model of the stream table.
  int          key2sid[logic [31:0]];
  bit          slot_used[64];
  logic [31:0] slot_key[64];
  logic [15:0] mask_m[64];
  int          victim = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    key2sid.delete();
    for (int i = 0; i < 64; i++) slot_used[i] = 0;
    victim    = 0;
    exp_pkts  = 0;
    exp_drops = 0;
  endtask

  task automatic model_lookup(input logic [31:0] key, output bit drop, output int sid,
                              output bit is_new);
    drop   = 0;
    is_new = 0;
    sid    = -1;
    if (key2sid.exists(key)) begin
      sid = key2sid[key];
    end else begin
      is_new = 1;
      for (int i = 0; i < 64; i++) if (!slot_used[i] && sid < 0) sid = i;
      if (sid < 0) begin
`ifdef DPI_FEEDER_EVICT_EN
        sid    = victim;
        victim = (victim + 1) % 64;
        key2sid.delete(slot_key[sid]);
`else
        drop = 1;
`endif
      end
      if (!drop) begin
        slot_used[sid] = 1;
        slot_key[sid]  = key;
        key2sid[key]   = sid;
        mask_m[sid]    = cfg_default_mask;
      end
    end
  endtask

  task automatic drive_beat(input logic sop, input logic eop_b, input logic [7:0] d,
                            input logic [31:0] key);
    int n = 0;
    pkt_vld  = 1;
    pkt_sop  = sop;
    pkt_eop  = eop_b;
    pkt_data = d;
    pkt_key  = key;
    while (!pkt_rdy && n < 100) begin
      tick(1);
      n++;
    end
    chk("pkt_rdy_wait", pkt_rdy, 1);
    tick(1);
    pkt_vld = 0;
  endtask

  task automatic cfg_write(input logic [5:0] sid, input logic [15:0] m);
    cfg_we   = 1;
    cfg_sid  = sid;
    cfg_mask = m;
    mask_m[sid] = m;
    tick(1);
    cfg_we = 0;
  endtask

  // Full packet of len bytes; fixed supplies bytes LSB-first when use_fixed is set.
  task automatic send_pkt(input logic [31:0] key, input int len, input int gap_pct,
                          input bit use_fixed, input logic [63:0] fixed);
    bit drop, is_new;
    int sid;
    logic [7:0] b;
    hdr_t h;
    model_lookup(key, drop, sid, is_new);
    if (drop) begin
      exp_drops++;
    end else begin
      h.sid = 6'(sid); h.nw = is_new; h.en = mask_m[sid]; h.len = 16'(len);
      exp_hdr.push_back(h);
      exp_pkts++;
    end
    for (int i = 0; i < len; i++) begin
      b = use_fixed ? fixed[8*i +: 8] : 8'($urandom_range(0, 255));
      if (!drop) exp_chars.push_back(b);
      if (i > 0 && $urandom_range(0, 99) < gap_pct) tick($urandom_range(1, 3));
      drive_beat(i == 0, i == len - 1, b, key);
    end
    tick(2);  // keep cfg changes clear of this packet's lookup
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_hdr.size() != 0 || exp_chars.size() != 0 || in_pkt) && n < 300) begin
      tick(1);
      n++;
    end
    chk("drain_queues", 64'(exp_hdr.size() + exp_chars.size()), 0);
    tick(3);
  endtask

  // Monitor
  bit   in_pkt = 0;
  hdr_t cur;
  int   cyc = 0, load_cyc = 0, last_cyc = 0, nchars = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_pkt = 0;
      end else begin
        if (load_state) begin
          chk("load_eop_exclusive", eop, 0);
          chk("load_while_busy", in_pkt, 0);
          if (exp_hdr.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_load: got load_state sid %0d expected none", stream_id);
          end else begin
            cur = exp_hdr.pop_front();
            chk("stream_id", stream_id, cur.sid);
            chk("new_stream_id", new_stream_id, cur.nw);
            chk("enable", enable, cur.en);
            in_pkt   = 1;
            load_cyc = cyc;
            nchars   = 0;
          end
        end
        if (char_in_vld) begin
          if (!in_pkt || exp_chars.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_char: got char %0h expected none", char_in);
          end else begin
            if (nchars == 0) chk("load_to_first_char", 64'(cyc - load_cyc), 2);
            chk("char_in", char_in, exp_chars.pop_front());
            nchars++;
            last_cyc = cyc;
          end
        end
        if (eop) begin
          if (!in_pkt) begin
            n_checks++;
            $display("FAIL unexpected_eop: got eop expected none");
          end else begin
            chk("char_count", 64'(nchars), 64'(cur.len));
            chk("eop_gap", 64'(cyc - last_cyc), EOP_GAP);
            chk("stream_id_hold", stream_id, cur.sid);
            chk("enable_hold", enable, cur.en);
            in_pkt = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] key;
    tick(3);
    // Reset state, sampled with reset still applied.
    chk("rst_pkt_rdy", pkt_rdy, 1);
    chk("rst_load_state", load_state, 0);
    chk("rst_char_vld", char_in_vld, 0);
    chk("rst_char_in", char_in, 0);
    chk("rst_eop", eop, 0);
    chk("rst_stream_id", stream_id, 0);
    chk("rst_enable", enable, 0);
    chk("rst_counters", {pkt_cnt, drop_cnt}, 0);
    rst = 0;
    model_reset();
    tick(1);

    send_pkt(32'hA, 3, 0, 1, 64'h636261);  // "abc"
    drive_beat(0, 0, 8'h55, 32'h0);        // stray mid-packet byte in IDLE
    send_pkt(32'hA, 2, 0, 0, 0);
    send_pkt(32'hB, 4, 0, 0, 0);
    cfg_write(6'd1, 16'h0005);
    send_pkt(32'hB, 3, 0, 0, 0);
    cfg_default_mask = 16'h1234;
    send_pkt(32'hC, 2, 0, 0, 0);
    drain();
    chk("pkt_cnt_basic", pkt_cnt, 16'(exp_pkts));

    // Reset during STREAM: sop + 2 bytes of a key-B packet, no eop.
    begin
      hdr_t h;
      int n = 0;
      h.sid = 6'd1; h.nw = 0; h.en = mask_m[1]; h.len = 16'd3;
      exp_hdr.push_back(h);
      for (int i = 0; i < 3; i++) begin
        exp_chars.push_back(8'h70 + 8'(i));
        drive_beat(i == 0, 0, 8'h70 + 8'(i), 32'hB);
      end
      while (exp_chars.size() != 0 && n < 50) begin
        tick(1);
        n++;
      end
      chk("pre_reset_chars", 64'(exp_chars.size()), 0);
      rst = 1;
      tick(1);
      chk("midrst_outputs", {load_state, char_in_vld, char_in, eop, stream_id, enable}, 0);
      chk("midrst_counters", {pkt_cnt, drop_cnt}, 0);
      chk("midrst_pkt_rdy", pkt_rdy, 1);
      tick(1);
      rst = 0;
      exp_hdr.delete();
      exp_chars.delete();
      model_reset();
      tick(1);
    end
    send_pkt(32'hB, 2, 0, 0, 0);  // table was cleared: new stream 0

    // Fill the remaining 63 entries, then a 65th key.
    for (int i = 0; i < 63; i++) send_pkt(32'h1000 + 32'(i), 1, 0, 0, 0);
    send_pkt(32'h2000, 3, 0, 0, 0);
    drain();
    chk("drop_cnt_full", drop_cnt, 16'(exp_drops));
    chk("pkt_cnt_full", pkt_cnt, 16'(exp_pkts));

    // One-byte packet and a long gappy packet on known keys.
    send_pkt(slot_key[5], 1, 0, 0, 0);
    send_pkt(slot_key[9], 8, 60, 0, 0);

    // Randomised traffic with mask updates.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(6'($urandom_range(0, 63)), 16'($urandom()));
      if ($urandom_range(0, 7) == 0) cfg_default_mask = 16'($urandom());
      key = ($urandom_range(0, 3) == 0) ? $urandom() : slot_key[$urandom_range(0, 63)];
      send_pkt(key, $urandom_range(1, 6), 30, 0, 0);
    end
    drain();
    chk("pkt_cnt_final", pkt_cnt, 16'(exp_pkts));
    chk("drop_cnt_final", drop_cnt, 16'(exp_drops));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
